crc_stream_engine: RTL

Parametrised, clocked CRC engine that folds a stream of DATA_W-bit beats into a CRC_W-bit remainder, one beat per cycle, under a valid/ready handshake. It generalises the fixed-width combinational next-CRC functions, such as the 33-bit / 264-bit one, to any polynomial, width, init and final-XOR. It owns the running CRC register and frame sequencing, and sits between a packet source and a checker/appender.

---
 rtl/crc_stream_engine.sv | 122 ++++++++++++
 1 files changed

// File: rtl/crc_stream_engine.sv
// Streaming CRC engine: folds DATA_W-bit beats MSB-first into a CRC_W-bit remainder under valid/ready.
// Optional CRC_CHECK_EN adds a registered compare of the final CRC against CHECK_VAL (crc_match).
module crc_stream_engine #(
  parameter int unsigned      CRC_W     = 33,
  parameter logic [CRC_W-1:0] POLY      = {CRC_W{1'b1}},
  parameter int unsigned      DATA_W    = 264,
  parameter logic [CRC_W-1:0] INIT      = '0,
  parameter logic [CRC_W-1:0] XOROUT    = '0,
  parameter logic [CRC_W-1:0] CHECK_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              crc_valid,
  input  logic              crc_ready,
  output logic [CRC_W-1:0]  crc_out,
  output logic              crc_match,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CRC_W-1:0]   crc_q, crc_d;
  logic [CRC_W-1:0]   out_d;
  logic               valid_d, busy_d;
  logic [CRC_W-1:0]   crc_new, crc_fin;
  logic               beat_fire;

  // Bit-serial MSB-first division unrolled across the whole beat.
  function automatic logic [CRC_W-1:0] crc_fold(input logic [CRC_W-1:0] c_in,
                                                input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    logic             fb;
    c = c_in;
    for (int i = int'(DATA_W) - 1; i >= 0; i--) begin
      fb = c[CRC_W-1] ^ d[i];
      c  = (c << 1) ^ (fb ? POLY : '0);
    end
    return c;
  endfunction

  assign s_ready   = !clr && ((state_q != HOLD) || crc_ready);
  assign beat_fire = s_valid && s_ready;
  // A frame's first beat always folds onto INIT, even straight out of HOLD.
  assign crc_new   = crc_fold((state_q == ACC) ? crc_q : INIT, s_data);
  assign crc_fin   = crc_new ^ XOROUT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      crc_q     <= INIT;
      crc_out   <= '0;
      crc_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      crc_out   <= out_d;
      crc_valid <= valid_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    out_d   = crc_out;
    valid_d = crc_valid;
    busy_d  = busy;
    if (clr) begin
      state_d = IDLE;
      crc_d   = INIT;
      out_d   = '0;
      valid_d = 1'b0;
      busy_d  = 1'b0;
    end else if (beat_fire) begin
      // In HOLD a beat is only accepted alongside the result handshake.
      if (s_last) begin
        state_d = HOLD;
        crc_d   = INIT;
        out_d   = crc_fin;
        valid_d = 1'b1;
        busy_d  = 1'b0;
      end else begin
        state_d = ACC;
        crc_d   = crc_new;
        valid_d = 1'b0;
        busy_d  = 1'b1;
      end
    end else if (state_q == HOLD && crc_ready) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end else if (state_q != IDLE && state_q != ACC && state_q != HOLD) begin
      state_d = IDLE;
    end
  end

`ifdef CRC_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_match <= 1'b0;
    end else if (clr) begin
      crc_match <= 1'b0;
    end else if (beat_fire && s_last) begin
      crc_match <= (crc_fin == CHECK_VAL);
    end
  end
`else
  // Comparator absent; CHECK_VAL is inert and folds away.
  assign crc_match = 1'b0 & (|CHECK_VAL);
`endif

endmodule
